fpga_reset_sequencer: RTL and testbench
=======================================

Name: fpga_reset_sequencer

Overview:
Board-level reset conditioner that sits directly upstream of the platform top in the FPGA wrapper and drives the platform's external_rstnn input. It synchronises and debounces the raw push-button reset, gates release on PLL/MMCM lock, and holds reset for a programmable time. It then releases reset in two stages: peripherals first, then the core platform. It also records the cause of the last reset for bring-up debug.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchronisers on button_rstnn and pll_locked (minimum 2)
DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples needed to change the debounced button level
HOLD_CYCLES, 64, cycles reset is held after button and lock are both good
STAGE_GAP, 8, cycles between periph_rstnn release and platform_rstnn release
CNT_WIDTH, 16, width of the internal counters; must hold max(DEBOUNCE_CYCLES, HOLD_CYCLES, STAGE_GAP)

Ports:
clk  input  1  free-running board clock (not the PLL output)
rstnn  input  1  synchronous active-low reset of this block
button_rstnn  input  1  raw board reset button, asynchronous, active-low
pll_locked  input  1  PLL/MMCM lock, asynchronous, active-high
periph_rstnn  output  1  peripheral reset, active-low, registered
platform_rstnn  output  1  platform reset, active-low, registered; feeds platform external_rstnn
seq_state  output  3  current FSM state code
reset_cause  output  2  bit0 = button, bit1 = lock loss; captures the last abort
reset_count  output  8  number of aborts from PERI/HOLD/RUN, saturating at 255

Behaviour:
- Reset, on rstnn low at a clk edge:
  - state = WAIT_LOCK (code 1); periph_rstnn = 0; platform_rstnn = 0; reset_cause = 0; reset_count = 0.
  - Synchroniser flops = 0; debounced button = 0; all counters = 0.
  - Reset asserted mid-sequence wins over everything else on that edge.
- Synchronisers: plain SYNC_STAGES-deep flop chains. A raw change is visible at the sync output SYNC_STAGES edges later.
- Debounce (button only):
  - Counter increments each cycle the sync output differs from the debounced level, and clears to 0 whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - Applies to both edges. Glitches shorter than DEBOUNCE_CYCLES are ignored.
  - pll_locked is not debounced; loss of lock takes effect immediately.
- Definition: good = debounced_button & lock_sync.
- FSM states (codes in seq_state):
  - WAIT_LOCK (1): if good, go to HOLD and clear the counter.
  - HOLD (2): count cycles. When HOLD_CYCLES have elapsed in HOLD, go to PERI and clear the counter.
  - PERI (3): count cycles. When STAGE_GAP have elapsed, go to RUN.
  - RUN (4): stay while good.
  - Codes 0 and 5-7 are unused; if reached, go to WAIT_LOCK.
- Abort: in HOLD, PERI or RUN, !good forces WAIT_LOCK on the next edge and clears the counter.
  - reset_cause is loaded with {~lock_sync, ~debounced_button}. If both are bad in the same cycle, both bits are set.
  - reset_count increments, saturating at 255.
  - WAIT_LOCK never records a cause.
- Outputs are registered and change on the same edge the state register changes:
  - periph_rstnn = 1 iff state is PERI or RUN.
  - platform_rstnn = 1 iff state is RUN.
  - On abort, both outputs drop on the edge the state enters WAIT_LOCK. There is no partial-deassert window.
  - platform_rstnn is never high while periph_rstnn is low.
- Latency, defaults, lock already steady high, from raw button rise at edge 0:
  - debounced level at edge 18
  - HOLD at 19
  - periph_rstnn high at 83
  - platform_rstnn high at 91
- A good/bad toggle back to good during HOLD restarts the full HOLD_CYCLES count from WAIT_LOCK; there is no resume.
- Boundary: HOLD_CYCLES = 0 or STAGE_GAP = 0 means one cycle in that state.

Test Plan:
- rstnn low for 4 cycles with button and lock high → during reset: outputs 0, seq_state = 1. After release: periph_rstnn rises at cycle 83 relative to sync start, platform_rstnn at 91.
- Steady RUN, then button low pulses of 10 and 15 cycles → no change. A 16-cycle low pulse → both resets drop at raw edge + 18, reset_cause = 01, reset_count = 1, then the full re-sequence.
- RUN, then pll_locked low for 1 cycle → both outputs low 2 cycles later, reset_cause = 10. Lock returns → periph_rstnn high 2 + 1 + 64 cycles after lock rise.
- Button and lock drop on the same edge while in PERI → reset_cause = 11; platform_rstnn never went high.
- Lock drop at cycle 30 of HOLD, restored 5 cycles later → HOLD restarts from 0; periph_rstnn rises 64 cycles after HOLD re-entry.
- 300 lock-loss aborts → reset_count saturates at 255; rstnn low mid-PERI → outputs 0, reset_count = 0 on the next edge.

Source files
------------

// File: rtl/fpga_reset_sequencer.sv
// Board reset conditioner: button/lock synchronisers, button debounce, programmable hold
// and a two-stage release (peripherals, then platform) with last-abort cause capture.
module fpga_reset_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 64,
  parameter int STAGE_GAP       = 8,
  parameter int CNT_WIDTH       = 16
) (
  input  logic       clk,
  input  logic       rstnn,
  input  logic       button_rstnn,
  input  logic       pll_locked,
  output logic       periph_rstnn,
  output logic       platform_rstnn,
  output logic [2:0] seq_state,
  output logic [1:0] reset_cause,
  output logic [7:0] reset_count
);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd1,
    ST_HOLD      = 3'd2,
    ST_PERI      = 3'd3,
    ST_RUN       = 3'd4
  } state_e;

  // A zero-length phase still occupies one cycle, so the terminal count floors at 0.
  localparam logic [CNT_WIDTH-1:0] DEB_LAST  =
    CNT_WIDTH'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST =
    CNT_WIDTH'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST  =
    CNT_WIDTH'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);

  logic [SYNC_STAGES-1:0] btn_sync_q;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   btn_sync_s;
  logic                   lock_sync_s;

  logic                   deb_q,     deb_d;
  logic [CNT_WIDTH-1:0]   deb_cnt_q, deb_cnt_d;

  state_e                 state_q,   state_d;
  logic [CNT_WIDTH-1:0]   seq_cnt_q, seq_cnt_d;
  logic [1:0]             cause_q,   cause_d;
  logic [7:0]             count_q,   count_d;
  logic                   periph_q,  periph_d;
  logic                   platform_q, platform_d;
  logic                   good_s;
  logic                   abort_s;

  assign btn_sync_s  = btn_sync_q[SYNC_STAGES-1];
  assign lock_sync_s = lock_sync_q[SYNC_STAGES-1];
  assign good_s      = deb_q & lock_sync_s;

  // Input synchroniser chains for the two asynchronous inputs.
  always_ff @(posedge clk) begin
    if (!rstnn) begin
      btn_sync_q  <= '0;
      lock_sync_q <= '0;
    end else begin
      btn_sync_q  <= {btn_sync_q[SYNC_STAGES-2:0], button_rstnn};
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (btn_sync_s != deb_q) begin
      if (deb_cnt_q >= DEB_LAST) begin
        deb_d     = ~deb_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + CNT_WIDTH'(1);
      end
    end else begin
      deb_cnt_d = '0;
    end
  end

  // Debounce state register.
  always_ff @(posedge clk) begin
    if (!rstnn) begin
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  // Sequencer next-state, abort capture and next output levels.
  always_comb begin
    state_d   = state_q;
    seq_cnt_d = seq_cnt_q;
    cause_d   = cause_q;
    count_d   = count_q;
    abort_s   = 1'b0;
    case (state_q)
      ST_WAIT_LOCK: begin
        seq_cnt_d = '0;
        if (good_s) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_HOLD: begin
        if (!good_s) begin
          abort_s = 1'b1;
        end else if (seq_cnt_q >= HOLD_LAST) begin
          state_d   = ST_PERI;
          seq_cnt_d = '0;
        end else begin
          seq_cnt_d = seq_cnt_q + CNT_WIDTH'(1);
        end
      end
      ST_PERI: begin
        if (!good_s) begin
          abort_s = 1'b1;
        end else if (seq_cnt_q >= GAP_LAST) begin
          state_d   = ST_RUN;
          seq_cnt_d = '0;
        end else begin
          seq_cnt_d = seq_cnt_q + CNT_WIDTH'(1);
        end
      end
      ST_RUN: begin
        if (!good_s) begin
          abort_s = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d   = ST_WAIT_LOCK;
        seq_cnt_d = '0;
      end
    endcase

    if (abort_s) begin
      state_d   = ST_WAIT_LOCK;
      seq_cnt_d = '0;
      cause_d   = {~lock_sync_s, ~deb_q};
      count_d   = (count_q == 8'd255) ? count_q : count_q + 8'd1;
    end else begin
      cause_d   = cause_q;
    end

    // Outputs follow the next state so they switch on the same edge as the state register.
    periph_d   = (state_d == ST_PERI) || (state_d == ST_RUN);
    platform_d = (state_d == ST_RUN);
  end

  // Sequencer state and registered reset outputs.
  always_ff @(posedge clk) begin
    if (!rstnn) begin
      state_q    <= ST_WAIT_LOCK;
      seq_cnt_q  <= '0;
      cause_q    <= 2'b00;
      count_q    <= 8'd0;
      periph_q   <= 1'b0;
      platform_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      seq_cnt_q  <= seq_cnt_d;
      cause_q    <= cause_d;
      count_q    <= count_d;
      periph_q   <= periph_d;
      platform_q <= platform_d;
    end
  end

  assign periph_rstnn   = periph_q;
  assign platform_rstnn = platform_q;
  assign seq_state      = state_q;
  assign reset_cause    = cause_q;
  assign reset_count    = count_q;

endmodule

// File: tb/tb_fpga_reset_sequencer.sv
// Randomised and directed bench for fpga_reset_sequencer against a timeline-style reference model.
module tb_fpga_reset_sequencer;

  localparam int SS   = 2;
  localparam int DEB  = 16;
  localparam int HOLD = 64;
  localparam int GAP  = 8;
  localparam int CW   = 16;

  logic       clk = 1'b0;
  logic       rstnn;
  logic       button_rstnn;
  logic       pll_locked;
  logic       periph_rstnn;
  logic       platform_rstnn;
  logic [2:0] seq_state;
  logic [1:0] reset_cause;
  logic [7:0] reset_count;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: delay lines, a stable-run counter and "time since sequence start".
  bit       q_btn[$];
  bit       q_lock[$];
  bit       m_deb;
  int       m_run;
  bit       m_active;
  int       m_t;
  bit [1:0] m_cause;
  int       m_count;

  fpga_reset_sequencer #(
    .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD),
    .STAGE_GAP(GAP), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rstnn(rstnn), .button_rstnn(button_rstnn), .pll_locked(pll_locked),
    .periph_rstnn(periph_rstnn), .platform_rstnn(platform_rstnn), .seq_state(seq_state),
    .reset_cause(reset_cause), .reset_count(reset_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    q_btn = {};
    q_lock = {};
    for (int i = 0; i < SS; i++) begin
      q_btn.push_back(1'b0);
      q_lock.push_back(1'b0);
    end
    m_deb = 1'b0; m_run = 0; m_active = 1'b0; m_t = 0; m_cause = 2'b00; m_count = 0;
  endtask

  task automatic model_step(input bit r, input bit b, input bit l);
    bit bs, ls, good;
    if (!r) begin
      model_reset();
    end else begin
      bs = q_btn[SS-1];
      ls = q_lock[SS-1];
      good = m_deb & ls;
      if (!m_active) begin
        if (good) begin m_active = 1'b1; m_t = 0; end
      end else if (!good) begin
        m_active = 1'b0;
        m_cause = {~ls, ~m_deb};
        if (m_count < 255) m_count++;
      end else if (m_t < 1000000) begin
        m_t++;
      end
      if (bs != m_deb) begin
        m_run++;
        if (m_run >= DEB) begin m_deb = ~m_deb; m_run = 0; end
      end else begin
        m_run = 0;
      end
      q_btn.push_front(b);  void'(q_btn.pop_back());
      q_lock.push_front(l); void'(q_lock.pop_back());
    end
  endtask

  function automatic int exp_state();
    int hl, gl;
    hl = (HOLD > 0) ? HOLD : 1;
    gl = (GAP > 0) ? GAP : 1;
    if (!m_active)         return 1;
    else if (m_t < hl)      return 2;
    else if (m_t < hl + gl) return 3;
    else                    return 4;
  endfunction

  // Drive one cycle of inputs, advance the model over the coming edge, check at the next negedge.
  task automatic tick(input bit r, input bit b, input bit l);
    int es;
    rstnn = r; button_rstnn = b; pll_locked = l;
    model_step(r, b, l);
    @(negedge clk);
    es = exp_state();
    check_eq("seq_state", 32'(seq_state), 32'(es));
    check_eq("periph_rstnn", 32'(periph_rstnn), 32'(es >= 3));
    check_eq("platform_rstnn", 32'(platform_rstnn), 32'(es == 4));
    check_eq("reset_cause", 32'(reset_cause), 32'(m_cause));
    check_eq("reset_count", 32'(reset_count), 32'(m_count));
  endtask

  initial begin
    int t_h, t_p, t_q, cnt_before, len, kind, total;
    bit seen_low, plat_seen, bb, ll;
    logic [2:0] prev_state;

    model_reset();
    repeat (4) tick(1'b0, 1'b1, 1'b1);
    check_eq("rst_state", 32'(seq_state), 32'd1);
    check_eq("rst_outputs", 32'({periph_rstnn, platform_rstnn}), 32'd0);
    check_eq("rst_count", 32'(reset_count), 32'd0);
    repeat (100) tick(1'b1, 1'b1, 1'b1);
    check_eq("first_run", 32'(platform_rstnn), 32'd1);

    // Release latency measured from a raw button rise.
    repeat (30) tick(1'b1, 1'b0, 1'b1);
    t_h = 0; t_p = 0; t_q = 0;
    for (int i = 1; i <= 120; i++) begin
      tick(1'b1, 1'b1, 1'b1);
      if (t_h == 0 && seq_state == 3'd2) t_h = i;
      if (t_p == 0 && periph_rstnn)      t_p = i;
      if (t_q == 0 && platform_rstnn)    t_q = i;
    end
    check_eq("lat_hold", 32'(t_h), 32'd19);
    check_eq("lat_periph", 32'(t_p), 32'd83);
    check_eq("lat_platform", 32'(t_q), 32'd91);

    // Button glitches of 10 and 15 are filtered, 16 aborts.
    cnt_before = int'(reset_count);
    repeat (10) tick(1'b1, 1'b0, 1'b1);
    repeat (40) tick(1'b1, 1'b1, 1'b1);
    repeat (15) tick(1'b1, 1'b0, 1'b1);
    repeat (40) tick(1'b1, 1'b1, 1'b1);
    check_eq("glitch_count", 32'(reset_count), 32'(cnt_before));
    check_eq("glitch_run", 32'(platform_rstnn), 32'd1);
    repeat (16) tick(1'b1, 1'b0, 1'b1);
    repeat (30) tick(1'b1, 1'b1, 1'b1);
    check_eq("btn16_cause", 32'(reset_cause), 32'd1);
    check_eq("btn16_count", 32'(reset_count), 32'(cnt_before + 1));
    repeat (100) tick(1'b1, 1'b1, 1'b1);

    // Single-cycle lock loss in RUN, then re-sequence from lock rise.
    tick(1'b1, 1'b1, 1'b0);
    seen_low = 1'b0; t_p = 0;
    for (int i = 1; i <= 100; i++) begin
      tick(1'b1, 1'b1, 1'b1);
      if (!periph_rstnn) seen_low = 1'b1;
      if (seen_low && t_p == 0 && periph_rstnn) t_p = i;
    end
    check_eq("lock_drop_seen", 32'(seen_low), 32'd1);
    check_eq("lock_cause", 32'(reset_cause), 32'd2);
    check_eq("lock_periph_lat", 32'(t_p), 32'd67);

    // Button and lock go bad together while in PERI.
    repeat (5) tick(1'b1, 1'b1, 1'b0);
    plat_seen = 1'b0;
    for (int i = 1; i <= 90; i++) begin
      tick(1'b1, (i < 51), (i < 67));
      if (platform_rstnn) plat_seen = 1'b1;
      if (i == 68) check_eq("both_in_peri", 32'(seq_state), 32'd3);
    end
    check_eq("both_cause", 32'(reset_cause), 32'd3);
    check_eq("both_no_platform", 32'(plat_seen), 32'd0);
    repeat (40) tick(1'b1, 1'b1, 1'b0);

    // Lock loss during HOLD restarts the whole hold count.
    t_h = 0; t_p = 0; prev_state = seq_state;
    for (int i = 1; i <= 160; i++) begin
      ll = !(i >= 33 && i <= 37);
      tick(1'b1, 1'b1, ll);
      if (prev_state != 3'd2 && seq_state == 3'd2) t_h = i;
      if (t_p == 0 && periph_rstnn) t_p = i;
      prev_state = seq_state;
    end
    check_eq("restart_hold_entry", 32'(t_h), 32'd40);
    check_eq("restart_periph", 32'(t_p), 32'd104);
    check_eq("restart_gap", 32'(t_p - t_h), 32'd64);

    // Saturating abort counter.
    for (int k = 0; k < 300; k++) begin
      for (int j = 0; j < 10; j++) begin
        tick(1'b1, 1'b1, 1'b1);
        if (m_active) break;
      end
      repeat (3) tick(1'b1, 1'b1, 1'b0);
    end
    check_eq("sat_count", 32'(reset_count), 32'd255);
    check_eq("sat_cause", 32'(reset_cause), 32'd2);

    // Block reset in the middle of PERI.
    repeat (70) tick(1'b1, 1'b1, 1'b1);
    check_eq("mid_peri_state", 32'(seq_state), 32'd3);
    tick(1'b0, 1'b1, 1'b1);
    check_eq("mid_rst_outputs", 32'({periph_rstnn, platform_rstnn}), 32'd0);
    check_eq("mid_rst_count", 32'(reset_count), 32'd0);
    check_eq("mid_rst_state", 32'(seq_state), 32'd1);
    check_eq("mid_rst_cause", 32'(reset_cause), 32'd0);

    // Randomised segments.
    total = 0;
    while (total < 4000) begin
      kind = int'($urandom_range(0, 9));
      if (kind <= 3) begin
        len = int'($urandom_range(5, 120));
        repeat (len) tick(1'b1, 1'b1, 1'b1);
      end else if (kind <= 5) begin
        len = int'($urandom_range(1, 24));
        repeat (len) tick(1'b1, 1'b0, 1'b1);
      end else if (kind <= 7) begin
        len = int'($urandom_range(1, 6));
        repeat (len) tick(1'b1, 1'b1, 1'b0);
      end else if (kind == 8) begin
        len = int'($urandom_range(1, 30));
        for (int i = 0; i < len; i++) begin
          bb = 1'($urandom);
          ll = 1'($urandom);
          tick(1'b1, bb, ll);
        end
      end else begin
        len = int'($urandom_range(1, 3));
        repeat (len) tick(1'b0, 1'($urandom), 1'($urandom));
      end
      total += len;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
